chan_responder: RTL and testbench

- Dispatcher-side server for the inter-CPU channel protocol.
- Accepts one request at a time from a CPU-side channel controller: `CPU_R_CHAN_CRT`, `_SET`, `_GET`, `_TST` or `_DEL`, qualified by cpu_msg_pulse.
- Executes the request against an internal table of NUM_CHAN channels. Each channel is a FIFO_DEPTH-word FIFO.
- Answers with a one-cycle `CPU_R_CHAN_DONE` carrying result data and a status flag.

---
 rtl/chan_responder_if.sv | 53 +++++
 rtl/chan_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_chan_responder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_responder_if.sv
// chan_responder_if: request/response bundle between a CPU-side channel
// controller (master) and the dispatcher-side channel server (slave).
// The message-code and field-width macros are defined here if the
// surrounding build has not already provided them.

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`endif
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 7
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 7
`endif
`ifndef CPU_R_CHAN_CRT
`define CPU_R_CHAN_CRT 4'd1
`endif
`ifndef CPU_R_CHAN_SET
`define CPU_R_CHAN_SET 4'd2
`endif
`ifndef CPU_R_CHAN_GET
`define CPU_R_CHAN_GET 4'd3
`endif
`ifndef CPU_R_CHAN_TST
`define CPU_R_CHAN_TST 4'd4
`endif
`ifndef CPU_R_CHAN_DEL
`define CPU_R_CHAN_DEL 4'd5
`endif
`ifndef CPU_R_CHAN_DONE
`define CPU_R_CHAN_DONE 4'd6
`endif

interface chan_responder_if;
  logic                     cpu_msg_pulse;
  logic [`CPU_MSG_SIZE0:0]  cpu_msg_in;
  logic [`ADDR_SIZE0:0]     addr_in;
  logic [`DATA_SIZE0:0]     data_in;
  logic [`CPU_MSG_SIZE0:0]  cpu_msg_out;
  logic [`DATA_SIZE0:0]     data_out;
  logic                     chan_ok;
  logic                     busy;

  modport master (
    output cpu_msg_pulse, cpu_msg_in, addr_in, data_in,
    input  cpu_msg_out, data_out, chan_ok, busy
  );

  modport slave (
    input  cpu_msg_pulse, cpu_msg_in, addr_in, data_in,
    output cpu_msg_out, data_out, chan_ok, busy
  );
endinterface

// File: rtl/chan_responder.sv
// chan_responder: serves CRT/SET/GET/TST/DEL requests against a table of
// NUM_CHAN small FIFOs and answers each with a one-cycle DONE.
// All state changes on the falling clock edge; rst is synchronous, active low.
// Optional macro CHAN_RESP_STATS_EN adds saturating served/failed/dropped
// counters as extra output ports.

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`endif
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 7
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 7
`endif
`ifndef CPU_R_CHAN_CRT
`define CPU_R_CHAN_CRT 4'd1
`endif
`ifndef CPU_R_CHAN_SET
`define CPU_R_CHAN_SET 4'd2
`endif
`ifndef CPU_R_CHAN_GET
`define CPU_R_CHAN_GET 4'd3
`endif
`ifndef CPU_R_CHAN_TST
`define CPU_R_CHAN_TST 4'd4
`endif
`ifndef CPU_R_CHAN_DEL
`define CPU_R_CHAN_DEL 4'd5
`endif
`ifndef CPU_R_CHAN_DONE
`define CPU_R_CHAN_DONE 4'd6
`endif

module chan_responder #(
  parameter int NUM_CHAN   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  chan_responder_if.slave  bus
`ifdef CHAN_RESP_STATS_EN
  ,
  output logic [31:0]      stat_served,
  output logic [31:0]      stat_failed,
  output logic [15:0]      stat_dropped
`endif
);

  localparam int MSG_W  = `CPU_MSG_SIZE0 + 1;
  localparam int ADDR_W = `ADDR_SIZE0 + 1;
  localparam int DATA_W = `DATA_SIZE0 + 1;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int IW     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [MSG_W-1:0]    r_code;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;

  logic                r_alloc [NUM_CHAN];
  logic [PW-1:0]       r_head  [NUM_CHAN];
  logic [PW-1:0]       r_tail  [NUM_CHAN];
  logic [CW-1:0]       r_count [NUM_CHAN];
  logic [DATA_W-1:0]   r_mem   [NUM_CHAN][FIFO_DEPTH];

  logic [MSG_W-1:0]    r_msgOut;
  logic [DATA_W-1:0]   r_dataOut;
  logic                r_chanOk;
  logic                r_busy;

  logic                w_codeKnown;
  logic                w_pulseAccept;
  logic [IW-1:0]       w_addrIdx;
  logic                w_handleOk;
  logic                w_anyFree;
  logic [IW-1:0]       w_freeIdx;
  logic [CW-1:0]       w_curCount;
  logic [DATA_W-1:0]   w_curHeadWord;
  logic                w_doCrt, w_doSet, w_doGet, w_doDel;
  logic                w_resOk;
  logic [DATA_W-1:0]   w_resData;

  assign bus.cpu_msg_out = r_msgOut;
  assign bus.data_out    = r_dataOut;
  assign bus.chan_ok     = r_chanOk;
  assign bus.busy        = r_busy;

  // Only the five request codes start a transaction; anything else is noise.
  always_comb begin
    w_codeKnown = 1'b0;
    case (bus.cpu_msg_in)
      `CPU_R_CHAN_CRT, `CPU_R_CHAN_SET, `CPU_R_CHAN_GET,
      `CPU_R_CHAN_TST, `CPU_R_CHAN_DEL: w_codeKnown = 1'b1;
      default: w_codeKnown = 1'b0;
    endcase
  end

  assign w_pulseAccept = bus.cpu_msg_pulse && w_codeKnown && (r_state == S_IDLE);

  // Handles are 1-based; zero or anything above NUM_CHAN never names a channel.
  assign w_addrIdx  = IW'(r_addr - ADDR_W'(1));
  assign w_handleOk = (r_addr != '0) && (r_addr <= ADDR_W'(NUM_CHAN)) && r_alloc[w_addrIdx];

  // Walk downward so the last hit is the lowest-index free channel.
  always_comb begin
    w_anyFree = 1'b0;
    w_freeIdx = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (!r_alloc[i]) begin
        w_anyFree = 1'b1;
        w_freeIdx = IW'(i);
      end
    end
  end

  // Decide the outcome of the latched request and which table edits it implies.
  always_comb begin
    w_doCrt       = 1'b0;
    w_doSet       = 1'b0;
    w_doGet       = 1'b0;
    w_doDel       = 1'b0;
    w_resOk       = 1'b0;
    w_resData     = '0;
    w_curCount    = r_count[w_addrIdx];
    w_curHeadWord = r_mem[w_addrIdx][r_head[w_addrIdx]];
    case (r_code)
      `CPU_R_CHAN_CRT: if (w_anyFree) begin
        w_doCrt   = 1'b1;
        w_resOk   = 1'b1;
        w_resData = DATA_W'(w_freeIdx) + DATA_W'(1);
      end
      `CPU_R_CHAN_SET: if (w_handleOk && (w_curCount < CW'(FIFO_DEPTH))) begin
        w_doSet   = 1'b1;
        w_resOk   = 1'b1;
        w_resData = DATA_W'(w_curCount + CW'(1));
      end
      `CPU_R_CHAN_GET: if (w_handleOk && (w_curCount != '0)) begin
        w_doGet   = 1'b1;
        w_resOk   = 1'b1;
        w_resData = w_curHeadWord;
      end
      `CPU_R_CHAN_TST: if (w_handleOk) begin
        w_resOk   = 1'b1;
        w_resData = DATA_W'(w_curCount);
      end
      `CPU_R_CHAN_DEL: if (w_handleOk) begin
        w_doDel   = 1'b1;
        w_resOk   = 1'b1;
        w_resData = DATA_W'(w_curCount);
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(negedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  // FSM sequencing: one execute cycle, one response cycle, back to idle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_pulseAccept) w_nextState = S_EXEC;
      S_EXEC:  w_nextState = S_RESP;
      S_RESP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Latch the request and drive the registered response fields.
  always_ff @(negedge clk) begin
    if (!rst) begin
      r_code    <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_msgOut  <= '0;
      r_dataOut <= '0;
      r_chanOk  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pulseAccept) begin
          r_code <= bus.cpu_msg_in;
          r_addr <= bus.addr_in;
          r_data <= bus.data_in;
          r_busy <= 1'b1;
        end
        S_EXEC: begin
          r_msgOut  <= `CPU_R_CHAN_DONE;
          r_dataOut <= w_resData;
          r_chanOk  <= w_resOk;
        end
        S_RESP: begin
          r_msgOut  <= '0;
          r_dataOut <= '0;
          r_chanOk  <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Channel bookkeeping: allocation flags, FIFO pointers and fill counts.
  always_ff @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        r_alloc[i] <= 1'b0;
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end
    end else if (r_state == S_EXEC) begin
      if (w_doCrt) begin
        r_alloc[w_freeIdx] <= 1'b1;
        r_head[w_freeIdx]  <= '0;
        r_tail[w_freeIdx]  <= '0;
        r_count[w_freeIdx] <= '0;
      end
      if (w_doSet) begin
        r_tail[w_addrIdx]  <= r_tail[w_addrIdx] + PW'(1);
        r_count[w_addrIdx] <= r_count[w_addrIdx] + CW'(1);
      end
      if (w_doGet) begin
        r_head[w_addrIdx]  <= r_head[w_addrIdx] + PW'(1);
        r_count[w_addrIdx] <= r_count[w_addrIdx] - CW'(1);
      end
      if (w_doDel) begin
        r_alloc[w_addrIdx] <= 1'b0;
        r_head[w_addrIdx]  <= '0;
        r_tail[w_addrIdx]  <= '0;
        r_count[w_addrIdx] <= '0;
      end
    end
  end

  // FIFO word storage; contents need no reset because counts gate every read.
  always_ff @(negedge clk) begin
    if (rst && (r_state == S_EXEC) && w_doSet) begin
      r_mem[w_addrIdx][r_tail[w_addrIdx]] <= r_data;
    end
  end

`ifdef CHAN_RESP_STATS_EN
  logic w_dropPulse;
  assign w_dropPulse = bus.cpu_msg_pulse && ((r_state != S_IDLE) || !w_codeKnown);

  // Saturating activity counters, sampled on the same cycle DONE is registered.
  always_ff @(negedge clk) begin
    if (!rst) begin
      stat_served  <= '0;
      stat_failed  <= '0;
      stat_dropped <= '0;
    end else begin
      if (r_state == S_EXEC) begin
        if (stat_served != '1) stat_served <= stat_served + 32'd1;
        if (!w_resOk && (stat_failed != '1)) stat_failed <= stat_failed + 32'd1;
      end
      if (w_dropPulse && (stat_dropped != '1)) stat_dropped <= stat_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chan_responder.sv
// tb_chan_responder: directed, table-driven bench for chan_responder.
// Inputs change on the rising edge, the DUT acts on the falling edge, and
// outputs are sampled on the rising edge.

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`endif
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 7
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 7
`endif
`ifndef CPU_R_CHAN_CRT
`define CPU_R_CHAN_CRT 4'd1
`endif
`ifndef CPU_R_CHAN_SET
`define CPU_R_CHAN_SET 4'd2
`endif
`ifndef CPU_R_CHAN_GET
`define CPU_R_CHAN_GET 4'd3
`endif
`ifndef CPU_R_CHAN_TST
`define CPU_R_CHAN_TST 4'd4
`endif
`ifndef CPU_R_CHAN_DEL
`define CPU_R_CHAN_DEL 4'd5
`endif
`ifndef CPU_R_CHAN_DONE
`define CPU_R_CHAN_DONE 4'd6
`endif

`timescale 1ns/1ps

module tb_chan_responder;

  typedef logic [`CPU_MSG_SIZE0:0] msg_t;
  typedef logic [`ADDR_SIZE0:0]    addr_t;
  typedef logic [`DATA_SIZE0:0]    data_t;

  typedef struct {
    msg_t  code;
    addr_t addr;
    data_t data;
    data_t expData;
    logic  expOk;
    logic  chkData;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int compareCount  = 0;
  int mismatchCount = 0;

  int expServed  = 0;
  int expFailed  = 0;
  int expDropped = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  chan_responder_if bus();

`ifdef CHAN_RESP_STATS_EN
  logic [31:0] statServed;
  logic [31:0] statFailed;
  logic [15:0] statDropped;
`endif

  chan_responder #(
    .NUM_CHAN   (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef CHAN_RESP_STATS_EN
    ,
    .stat_served  (statServed),
    .stat_failed  (statFailed),
    .stat_dropped (statDropped)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input msg_t code, input addr_t addr, input data_t data,
                        input data_t expData, input logic expOk, input logic chkData);
    vec_t v;
    v.code    = code;
    v.addr    = addr;
    v.data    = data;
    v.expData = expData;
    v.expOk   = expOk;
    v.chkData = chkData;
    vecs.push_back(v);
  endtask

  // Drives a one-cycle request; returns at the rising edge after it was sampled.
  task automatic applyStimulus(input msg_t code, input addr_t addr, input data_t data);
    @(posedge clk);
    bus.cpu_msg_pulse = 1'b1;
    bus.cpu_msg_in    = code;
    bus.addr_in       = addr;
    bus.data_in       = data;
    @(posedge clk);
    bus.cpu_msg_pulse = 1'b0;
    bus.cpu_msg_in    = '0;
    bus.addr_in       = '0;
    bus.data_in       = '0;
  endtask

  // Full request/response with exact latency and busy-window checks.
  task automatic runTransaction(input string tag, input msg_t code, input addr_t addr, input data_t data,
                                input data_t expData, input logic expOk, input logic chkData);
    applyStimulus(code, addr, data);
    checkOutput({tag, " busy@+1"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " noDone@+1"}, 32'(bus.cpu_msg_out), 32'd0);
    @(posedge clk);
    checkOutput({tag, " done"}, 32'(bus.cpu_msg_out), 32'(`CPU_R_CHAN_DONE));
    checkOutput({tag, " busy@+2"}, 32'(bus.busy), 32'd1);
    if (chkData) checkOutput({tag, " data"}, 32'(bus.data_out), 32'(expData));
    checkOutput({tag, " ok"}, 32'(bus.chan_ok), 32'(expOk));
    @(posedge clk);
    checkOutput({tag, " idleMsg"}, 32'(bus.cpu_msg_out), 32'd0);
    checkOutput({tag, " idleData"}, 32'(bus.data_out), 32'd0);
    checkOutput({tag, " idleOk"}, 32'(bus.chan_ok), 32'd0);
    checkOutput({tag, " idleBusy"}, 32'(bus.busy), 32'd0);
    expServed++;
    if (!expOk) expFailed++;
  endtask

  initial begin
    bus.cpu_msg_pulse = 1'b0;
    bus.cpu_msg_in    = '0;
    bus.addr_in       = '0;
    bus.data_in       = '0;

    // Basic allocation, push/pop order, empty, full, wrap, exhaustion, bad handles.
    addVec(`CPU_R_CHAN_CRT, 8'd0, 8'h00, 8'd1,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_CRT, 8'd0, 8'h00, 8'd2,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_CRT, 8'd0, 8'h00, 8'd3,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd1, 8'hA5, 8'd1,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd1, 8'h5A, 8'd2,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_TST, 8'd1, 8'h00, 8'd2,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_GET, 8'd1, 8'h00, 8'hA5, 1'b1, 1'b1);
    addVec(`CPU_R_CHAN_GET, 8'd1, 8'h00, 8'h5A, 1'b1, 1'b1);
    addVec(`CPU_R_CHAN_GET, 8'd1, 8'h00, 8'h00, 1'b0, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd1, 8'h11, 8'd1,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd1, 8'h22, 8'd2,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd1, 8'h33, 8'd3,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd1, 8'h44, 8'd4,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd1, 8'h55, 8'd0,  1'b0, 1'b0);
    addVec(`CPU_R_CHAN_GET, 8'd1, 8'h00, 8'h11, 1'b1, 1'b1);
    addVec(`CPU_R_CHAN_GET, 8'd1, 8'h00, 8'h22, 1'b1, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd1, 8'h66, 8'd3,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd1, 8'h77, 8'd4,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_GET, 8'd1, 8'h00, 8'h33, 1'b1, 1'b1);
    addVec(`CPU_R_CHAN_GET, 8'd1, 8'h00, 8'h44, 1'b1, 1'b1);
    addVec(`CPU_R_CHAN_GET, 8'd1, 8'h00, 8'h66, 1'b1, 1'b1);
    addVec(`CPU_R_CHAN_GET, 8'd1, 8'h00, 8'h77, 1'b1, 1'b1);
    addVec(`CPU_R_CHAN_TST, 8'd1, 8'h00, 8'd0,  1'b1, 1'b1);
    for (int h = 4; h <= 8; h++) addVec(`CPU_R_CHAN_CRT, 8'd0, 8'h00, data_t'(h), 1'b1, 1'b1);
    addVec(`CPU_R_CHAN_CRT, 8'd0, 8'h00, 8'd0,  1'b0, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd3, 8'h99, 8'd1,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_DEL, 8'd3, 8'h00, 8'd1,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_TST, 8'd3, 8'h00, 8'd0,  1'b0, 1'b1);
    addVec(`CPU_R_CHAN_CRT, 8'd0, 8'h00, 8'd3,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_TST, 8'd3, 8'h00, 8'd0,  1'b1, 1'b1);
    addVec(`CPU_R_CHAN_GET, 8'd3, 8'h00, 8'd0,  1'b0, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd0, 8'h12, 8'd0,  1'b0, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'd9, 8'h12, 8'd0,  1'b0, 1'b1);
    addVec(`CPU_R_CHAN_SET, 8'h81, 8'h12, 8'd0, 1'b0, 1'b1);

    // Reset state.
    repeat (3) @(posedge clk);
    checkOutput("reset msg", 32'(bus.cpu_msg_out), 32'd0);
    checkOutput("reset data", 32'(bus.data_out), 32'd0);
    checkOutput("reset ok", 32'(bus.chan_ok), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      runTransaction($sformatf("vec%0d", i), vecs[i].code, vecs[i].addr, vecs[i].data,
                     vecs[i].expData, vecs[i].expOk, vecs[i].chkData);
    end

    // Pulses while busy (sampled in EXEC and in RESP) are dropped.
    @(posedge clk);
    bus.cpu_msg_pulse = 1'b1;
    bus.cpu_msg_in    = `CPU_R_CHAN_SET;
    bus.addr_in       = 8'd2;
    bus.data_in       = 8'hC3;
    @(posedge clk);
    checkOutput("busyDrop busy", 32'(bus.busy), 32'd1);
    bus.data_in = 8'hD4;
    @(posedge clk);
    checkOutput("busyDrop done", 32'(bus.cpu_msg_out), 32'(`CPU_R_CHAN_DONE));
    checkOutput("busyDrop data", 32'(bus.data_out), 32'd1);
    checkOutput("busyDrop ok", 32'(bus.chan_ok), 32'd1);
    expServed++;
    expDropped += 2;
    @(posedge clk);
    bus.cpu_msg_pulse = 1'b0;
    bus.cpu_msg_in    = '0;
    bus.addr_in       = '0;
    bus.data_in       = '0;
    checkOutput("busyDrop idle busy", 32'(bus.busy), 32'd0);
    repeat (3) begin
      @(posedge clk);
      checkOutput("busyDrop noExtraDone", 32'(bus.cpu_msg_out), 32'd0);
      checkOutput("busyDrop noExtraBusy", 32'(bus.busy), 32'd0);
    end
    runTransaction("busyDrop tst", `CPU_R_CHAN_TST, 8'd2, 8'h00, 8'd1, 1'b1, 1'b1);
    runTransaction("busyDrop get", `CPU_R_CHAN_GET, 8'd2, 8'h00, 8'hC3, 1'b1, 1'b1);

    // Unrecognised codes in IDLE are ignored.
    applyStimulus(4'd0, 8'd1, 8'h00);
    applyStimulus(`CPU_R_CHAN_DONE, 8'd1, 8'h00);
    expDropped += 2;
    repeat (3) begin
      @(posedge clk);
      checkOutput("badCode noDone", 32'(bus.cpu_msg_out), 32'd0);
      checkOutput("badCode noBusy", 32'(bus.busy), 32'd0);
    end

`ifdef CHAN_RESP_STATS_EN
    checkOutput("stat served", statServed, 32'(expServed));
    checkOutput("stat failed", statFailed, 32'(expFailed));
    checkOutput("stat dropped", 32'(statDropped), 32'(expDropped));
`endif

    // Reset while the request is executing: no response, table cleared.
    @(posedge clk);
    bus.cpu_msg_pulse = 1'b1;
    bus.cpu_msg_in    = `CPU_R_CHAN_SET;
    bus.addr_in       = 8'd1;
    bus.data_in       = 8'hEE;
    @(posedge clk);
    bus.cpu_msg_pulse = 1'b0;
    bus.cpu_msg_in    = '0;
    bus.addr_in       = '0;
    bus.data_in       = '0;
    checkOutput("midReset busyBefore", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    checkOutput("midReset msg", 32'(bus.cpu_msg_out), 32'd0);
    checkOutput("midReset data", 32'(bus.data_out), 32'd0);
    checkOutput("midReset ok", 32'(bus.chan_ok), 32'd0);
    checkOutput("midReset busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    expServed  = 0;
    expFailed  = 0;
    expDropped = 0;
    @(posedge clk);
    checkOutput("postReset noDone", 32'(bus.cpu_msg_out), 32'd0);
    runTransaction("postReset tst", `CPU_R_CHAN_TST, 8'd1, 8'h00, 8'd0, 1'b0, 1'b1);
    runTransaction("postReset crt", `CPU_R_CHAN_CRT, 8'd0, 8'h00, 8'd1, 1'b1, 1'b1);

`ifdef CHAN_RESP_STATS_EN
    checkOutput("stat served post", statServed, 32'(expServed));
    checkOutput("stat failed post", statFailed, 32'(expFailed));
    checkOutput("stat dropped post", 32'(statDropped), 32'(expDropped));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
